aidc_lite_comp_zrle: RTL and testbench

- Zero-run-length (ZRLE) compressor for one 1024-bit block, delivered as 16 x 64-bit words.
- Encodes each word as a zero/non-zero lane-mask code plus its non-zero 16-bit lanes, and packs the bitstream MSB-first into 32-bit output words.
- The output stream has the framing the ZRLE decompressor consumes:
  - sop on the first word;
  - bits [31:30] of the first word carry the algorithm prefix;
  - eop on the last word.
- Sits in the compression path alongside the other AIDC-Lite compressors, feeding the selector/packer.

---
 rtl/aidc_lite_pkg.sv | 24 ++
 rtl/aidc_lite_zrle_enc.sv | 27 ++
 rtl/aidc_lite_comp_zrle.sv | 96 +++++++++
 tb/tb_aidc_lite_comp_zrle.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_pkg.sv
// aidc_lite_pkg: shared constants, ZRLE code tables and state type for the AIDC-Lite compressors
package aidc_lite_pkg;
    localparam logic [1:0] ALGO_ZRLE      = 2'b01;
    localparam int         ZRLE_NUM_WORDS = 16;
    localparam int         ZRLE_BUF_W     = 128;
    localparam logic [6:0] LEN_4Z    = 7'd6;
    localparam logic [6:0] LEN_3Z_LO = 7'd22;
    localparam logic [6:0] LEN_3Z    = 7'd21;
    localparam logic [6:0] LEN_2Z    = 7'd36;
    localparam logic [6:0] LEN_1Z    = 7'd52;
    localparam logic [6:0] LEN_0Z    = 7'd66;
    // Indexed by non-zero lane mask (bit i = lane i non-zero); prefixes right-aligned
    localparam logic [5:0] ZRLE_PFX [16] = '{
        6'b000000, 6'b000001, 6'b000001, 6'b000010,
        6'b000010, 6'b000011, 6'b000101, 6'b001000,
        6'b000011, 6'b000100, 6'b000110, 6'b001001,
        6'b000111, 6'b001010, 6'b001011, 6'b000011};
    localparam logic [6:0] ZRLE_LEN [16] = '{
        LEN_4Z, LEN_3Z_LO, LEN_3Z, LEN_2Z,
        LEN_3Z, LEN_2Z,    LEN_2Z, LEN_1Z,
        LEN_3Z, LEN_2Z,    LEN_2Z, LEN_1Z,
        LEN_2Z, LEN_1Z,    LEN_1Z, LEN_0Z};
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} zrle_state_t;
endpackage

// File: rtl/aidc_lite_zrle_enc.sv
// aidc_lite_zrle_enc: combinational ZRLE encoding of one 64-bit word into a left-aligned code
module aidc_lite_zrle_enc
    import aidc_lite_pkg::*;
(
    input  logic [63:0] data,
    output logic [65:0] code,
    output logic [6:0]  len
);
    logic [3:0]  m;
    logic [2:0]  plen;
    logic [63:0] lanes;
    logic [6:0]  pos;

    always_comb begin
        m = {|data[63:48], |data[47:32], |data[31:16], |data[15:0]};
        len = ZRLE_LEN[m];
        lanes = '0;
        pos = '0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) begin
                lanes = lanes | ({data[16*i +: 16], 48'b0} >> pos);
                pos = pos + 7'd16;
            end
        plen = 3'(len - pos);
        code = ({ZRLE_PFX[m], 60'b0} << (3'd6 - plen)) | ({lanes, 2'b0} >> plen);
    end
endmodule

// File: rtl/aidc_lite_comp_zrle.sv
// aidc_lite_comp_zrle: zero-run-length compressor, 16x64-bit block in, MSB-first 32-bit words out
module aidc_lite_comp_zrle
    import aidc_lite_pkg::*;
#(
    parameter logic [1:0] ALGO_ID   = ALGO_ZRLE,
    parameter int         NUM_WORDS = ZRLE_NUM_WORDS,
    parameter int         BUF_W     = ZRLE_BUF_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [63:0] data_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic [31:0] data_o,
    output logic        done_o,
    output logic [5:0]  size_o
);
    localparam int CW = $clog2(BUF_W + 1);
    localparam int IW = $clog2(NUM_WORDS + 1);

    zrle_state_t    state, state_d;
    logic [BUF_W-1:0] acc, acc_d, acc_ae;
    logic [CW-1:0]  buf_cnt, buf_cnt_d, cnt_ae;
    logic [IW-1:0]  in_cnt, in_cnt_d;
    logic [5:0]     out_cnt, out_cnt_d;
    logic [65:0]    code;
    logic [6:0]     len;
    logic           emit, accept, fin;

    aidc_lite_zrle_enc u_enc (.data(data_i), .code(code), .len(len));

    always_comb begin
        emit = (state == RUN && buf_cnt >= CW'(32)) || (state == FLUSH && buf_cnt != '0);
        cnt_ae = !emit ? buf_cnt : (buf_cnt >= CW'(32) ? buf_cnt - CW'(32) : '0);
        acc_ae = emit ? acc << 32 : acc;
        // Room for a worst-case code guarantees the append never overflows the accumulator
        ready_o = state == IDLE ||
                  (state == RUN && in_cnt < IW'(NUM_WORDS) && cnt_ae <= CW'(BUF_W - 66));
        accept = valid_i && ready_o;
        fin = state == FLUSH && cnt_ae == '0;
        state_d = state;
        acc_d = acc_ae;
        buf_cnt_d = cnt_ae;
        in_cnt_d = in_cnt;
        out_cnt_d = emit ? out_cnt + 6'd1 : out_cnt;
        if (state == IDLE) begin
            if (accept) begin
                acc_d = {ALGO_ID, code, {(BUF_W-68){1'b0}}};
                buf_cnt_d = CW'(len) + CW'(2);
                in_cnt_d = IW'(1);
                out_cnt_d = '0;
                state_d = RUN;
            end
        end else if (accept) begin
            acc_d = acc_ae | ({code, {(BUF_W-66){1'b0}}} >> cnt_ae);
            buf_cnt_d = cnt_ae + CW'(len);
            in_cnt_d = in_cnt + IW'(1);
            state_d = in_cnt == IW'(NUM_WORDS - 1) ? FLUSH : RUN;
        end
        if (fin)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            buf_cnt <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            valid_o <= 1'b0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
            done_o  <= 1'b0;
            data_o  <= '0;
            size_o  <= '0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            buf_cnt <= buf_cnt_d;
            in_cnt  <= in_cnt_d;
            out_cnt <= out_cnt_d;
            valid_o <= emit;
            sop_o   <= emit && out_cnt == '0;
            eop_o   <= fin;
            done_o  <= fin;
            if (emit)
                data_o <= acc[BUF_W-1 -: 32];
            if (fin)
                size_o <= out_cnt + 6'd1;
        end
    end
endmodule

// File: tb/tb_aidc_lite_comp_zrle.sv
// tb_aidc_lite_comp_zrle: randomized self-checking bench with a bit-queue ZRLE model and decoder
module tb_aidc_lite_comp_zrle;
    typedef logic [63:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [63:0] data_i = '0;
    logic        ready_o, valid_o, sop_o, eop_o, done_o;
    logic [31:0] data_o;
    logic [5:0]  size_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] got_w[$], exp_w[$];
    bit          got_sop[$], got_eop[$], got_don[$], exp_sop[$], exp_eop[$];
    int          got_size[$], exp_size[$], sop_cyc[$], eop_cyc[$];
    logic [63:0] blk_in[$];

    aidc_lite_comp_zrle dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o),
        .data_o(data_o), .done_o(done_o), .size_o(size_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) begin
            got_w.push_back(data_o);
            got_sop.push_back(sop_o);
            got_eop.push_back(eop_o);
            got_don.push_back(done_o);
            if (sop_o) sop_cyc.push_back(cyc);
            if (eop_o) eop_cyc.push_back(cyc);
        end
        if (done_o) got_size.push_back(int'(size_o));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Prefix table written straight from the code list: mask bit l set = lane l non-zero
    function automatic void zpfx(input logic [3:0] m, output int v, output int n);
        case (m)
            4'b0000: begin v = 0;  n = 6; end
            4'b0001: begin v = 1;  n = 6; end
            4'b0010: begin v = 1;  n = 5; end
            4'b0100: begin v = 2;  n = 5; end
            4'b1000: begin v = 3;  n = 5; end
            4'b0011: begin v = 2;  n = 4; end
            4'b0101: begin v = 3;  n = 4; end
            4'b1001: begin v = 4;  n = 4; end
            4'b0110: begin v = 5;  n = 4; end
            4'b1010: begin v = 6;  n = 4; end
            4'b1100: begin v = 7;  n = 4; end
            4'b0111: begin v = 8;  n = 4; end
            4'b1011: begin v = 9;  n = 4; end
            4'b1101: begin v = 10; n = 4; end
            4'b1110: begin v = 11; n = 4; end
            default: begin v = 3;  n = 2; end
        endcase
    endfunction

    task automatic model_block(input blk_t w);
        bit q[$];
        int v, n, nw;
        logic [3:0] m;
        logic [31:0] word;
        q.push_back(1'b0);
        q.push_back(1'b1);
        for (int i = 0; i < 16; i++) begin
            for (int l = 0; l < 4; l++) m[l] = w[i][16*l +: 16] != 16'h0;
            zpfx(m, v, n);
            for (int k = n - 1; k >= 0; k--) q.push_back(v[k]);
            for (int l = 3; l >= 0; l--)
                if (m[l]) for (int k = 15; k >= 0; k--) q.push_back(w[i][16*l + k]);
            blk_in.push_back(w[i]);
        end
        while (q.size() % 32 != 0) q.push_back(1'b0);
        nw = q.size() / 32;
        for (int k = 0; k < nw; k++) begin
            for (int j = 0; j < 32; j++) word[31-j] = q[32*k + j];
            exp_w.push_back(word);
            exp_sop.push_back(k == 0);
            exp_eop.push_back(k == nw - 1);
        end
        exp_size.push_back(nw);
    endtask

    task automatic decode_check(input string tag, input int off, input int nw, input int bi);
        bit b[$];
        int p, v, n, pv, pn, found;
        logic [63:0] word;
        for (int k = off; k < off + nw && k < got_w.size(); k++)
            for (int j = 31; j >= 0; j--) b.push_back(got_w[k][j]);
        while (b.size() < 1100) b.push_back(1'b0);
        chk({tag, "_algo"}, {b[0], b[1]}, 2'b01);
        p = 2;
        for (int wi = 0; wi < 16; wi++) begin
            found = -1;
            for (n = 2; n <= 6 && found < 0; n++) begin
                v = 0;
                for (int k = 0; k < n; k++) v = (v << 1) | int'(b[p + k]);
                for (int m = 0; m < 16; m++) begin
                    zpfx(4'(m), pv, pn);
                    if (pn == n && pv == v) found = m;
                end
                if (found >= 0) p += n;
            end
            if (found < 0) begin
                chk($sformatf("%s_rt_pfx%0d", tag, wi), 0, 1);
                return;
            end
            word = '0;
            for (int l = 3; l >= 0; l--)
                if (found[l]) begin
                    for (int k = 15; k >= 0; k--) word[16*l + k] = b[p + 15 - k];
                    p += 16;
                end
            chk($sformatf("%s_rt%0d", tag, wi), word, blk_in[bi*16 + wi]);
        end
    endtask

    task automatic clr();
        got_w.delete(); got_sop.delete(); got_eop.delete(); got_don.delete();
        got_size.delete(); sop_cyc.delete(); eop_cyc.delete();
        exp_w.delete(); exp_sop.delete(); exp_eop.delete(); exp_size.delete(); blk_in.delete();
    endtask

    task automatic send_block(input blk_t w, input int n, input bit gaps, output int stalls);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            valid_i = 1'b1;
            data_i = w[i];
            for (int t = 0; t <= 200; t++) begin
                @(negedge clk);
                if (ready_o) break;
                stalls++;
                if (t == 200) chk("accept_timeout", 0, 1);
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic verify(input string tag);
        int t = 0;
        int off = 0;
        while (got_size.size() < exp_size.size() && t < 3000) begin @(posedge clk); #1; t++; end
        repeat (4) begin @(posedge clk); #1; end
        chk({tag, "_nblk"}, got_size.size(), exp_size.size());
        chk({tag, "_nw"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
            chk($sformatf("%s_sop%0d", tag, i), got_sop[i], exp_sop[i]);
            chk($sformatf("%s_eop%0d", tag, i), got_eop[i], exp_eop[i]);
            chk($sformatf("%s_done%0d", tag, i), got_don[i], exp_eop[i]);
        end
        for (int b = 0; b < exp_size.size() && b < got_size.size(); b++) begin
            chk($sformatf("%s_size%0d", tag, b), got_size[b], exp_size[b]);
            decode_check($sformatf("%s_b%0d", tag, b), off, exp_size[b], b);
            off += exp_size[b];
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_sop"}, sop_o, 1'b0);
        chk({tag, "_eop"}, eop_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_data"}, data_o, 32'h0);
        chk({tag, "_size"}, size_o, 6'h0);
        chk({tag, "_ready"}, ready_o, 1'b1);
    endtask

    task automatic rnd_blk(output blk_t w);
        for (int i = 0; i < 16; i++)
            for (int l = 0; l < 4; l++)
                w[i][16*l +: 16] = $urandom_range(0, 1) ? 16'($urandom_range(1, 65535)) : 16'h0;
    endtask

    function automatic logic [31:0] gw(input int i);
        return (i >= 0 && i < got_w.size()) ? got_w[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        blk_t w, w2;
        int st, ne;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst("rst0");
        @(posedge clk); #1;
        rst_n = 1'b1;

        clr();
        w = '{default: 64'h0};
        model_block(w);
        send_block(w, 16, 1'b0, st);
        verify("zero");
        chk("zero_first", gw(0), 32'h4000_0000);
        chk("zero_sz", size_o, 6'd4);
        chk("zero_stall", st, 0);

        clr();
        w = '{default: 64'h0};
        w[0] = 64'h0000_0000_0000_1234;
        model_block(w);
        send_block(w, 16, 1'b0, st);
        verify("one");
        chk("one_first", gw(0), 32'h4112_3400);
        chk("one_sz", size_o, 6'd4);

        clr();
        w = '{default: 64'hFFFF_FFFF_FFFF_FFFF};
        model_block(w);
        send_block(w, 16, 1'b0, st);
        verify("ones");
        chk("ones_first", gw(0), 32'h7FFF_FFFF);
        chk("ones_last", gw(got_w.size() - 1), 32'hC000_0000);
        chk("ones_sz", size_o, 6'd34);
        chk("ones_stalled", st > 0, 1'b1);

        clr();
        for (int i = 0; i < 16; i++)
            for (int l = 0; l < 4; l++)
                w[i][16*l +: 16] = i[l] ? {8'(i*4 + l + 1), 8'($urandom)} : 16'h0;
        model_block(w);
        send_block(w, 16, 1'b1, st);
        verify("mask");

        clr();
        w = '{default: 64'h0123_4567_89AB_CDEF};
        send_block(w, 8, 1'b0, st);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_rst("rst1");
        ne = 0;
        foreach (got_eop[i]) ne += int'(got_eop[i]);
        chk("abort_eop", ne, 0);
        chk("abort_done", got_size.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr();
        w = '{default: 64'h0};
        model_block(w);
        send_block(w, 16, 1'b0, st);
        verify("post_rst");
        chk("post_rst_first", gw(0), 32'h4000_0000);
        chk("post_rst_sz", size_o, 6'd4);

        clr();
        rnd_blk(w);
        rnd_blk(w2);
        w2[0] = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        model_block(w);
        model_block(w2);
        send_block(w, 16, 1'b0, st);
        send_block(w2, 16, 1'b0, st);
        verify("b2b");
        chk("b2b_gap", (sop_cyc.size() > 1 && eop_cyc.size() > 0) ? sop_cyc[1] - eop_cyc[0] : -1, 2);

        clr();
        for (int b = 0; b < 4; b++) begin
            rnd_blk(w);
            model_block(w);
            send_block(w, 16, 1'b1, st);
        end
        verify("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
